// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: default counter width and
// the FSM state encoding.
package countdown_pkg;

    localparam int unsigned WIDTH_DEFAULT = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage : countdown_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with pause, sticky expired flag and a one-cycle
// done pulse. The counter never wraps; reaching zero parks the FSM in DONE.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | count holds the start value, waiting for start
// RUN     | count decrements once per edge while pause is low
// PAUSED  | countdown frozen, resumes (without decrement) when pause drops
// DONE    | count is 0, expired held high until load or restart
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             done_pulse
);

    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             expired_q, expired_d;
    logic             done_pulse_q, done_pulse_d;

    // Next-state and next-output computation; load overrides everything.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        reload_d     = reload_q;
        expired_d    = expired_q;
        done_pulse_d = 1'b0;

        if (load) begin
            state_d   = ST_IDLE;
            count_d   = load_value;
            reload_d  = load_value;
            expired_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (count_q == ZERO) begin
                            state_d      = ST_DONE;
                            expired_d    = 1'b1;
                            done_pulse_d = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (count_q <= ONE) begin
                        // Also covers a zero count so the counter can never wrap.
                        count_d      = ZERO;
                        state_d      = ST_DONE;
                        expired_d    = 1'b1;
                        done_pulse_d = 1'b1;
                    end else begin
                        count_d = count_q - ONE;
                    end
                end
                ST_PAUSED: begin
                    if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        count_d = reload_q;
                        if (reload_q == ZERO) begin
                            // Restart with a zero reload finishes immediately again.
                            expired_d    = 1'b1;
                            done_pulse_d = 1'b1;
                        end else begin
                            expired_d = 1'b0;
                            state_d   = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= ALL_ONES;
            reload_q     <= ALL_ONES;
            busy_q       <= 1'b0;
            expired_q    <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            reload_q     <= reload_d;
            busy_q       <= busy_d;
            expired_q    <= expired_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign count      = count_q;
    assign busy       = busy_q;
    assign expired    = expired_q;
    assign done_pulse = done_pulse_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: the driver applies stimulus, runs a
// behavioural model and queues the expected outputs; a monitor compares them.
module tb_countdown_timer;

    localparam int W = 5;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic [W-1:0] count;
    logic         busy;
    logic         expired;
    logic         done_pulse;

    countdown_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .count      (count),
        .busy       (busy),
        .expired    (expired),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        bit busy;
        bit expired;
        bit done;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: remaining count, last loaded value, activity flags.
    int rem;
    int reload;
    bit counting;   // timer actively counting
    bit frozen;     // countdown suspended by pause
    bit finished;   // reached zero, waiting for load/restart
    bit m_expired;
    bit m_pulse;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        rem       = MAXV;
        reload    = MAXV;
        counting  = 0;
        frozen    = 0;
        finished  = 0;
        m_expired = 0;
        m_pulse   = 0;
    endfunction

    function automatic void finish_now();
        rem       = 0;
        counting  = 0;
        finished  = 1;
        m_expired = 1;
        m_pulse   = 1;
    endfunction

    function automatic void model_edge(input bit l, input int v, input bit s, input bit p);
        m_pulse = 0;
        if (l) begin
            rem = v; reload = v; m_expired = 0;
            counting = 0; frozen = 0; finished = 0;
        end else if (finished) begin
            if (s) begin
                if (reload == 0) finish_now();
                else begin
                    rem = reload; m_expired = 0; finished = 0; counting = 1;
                end
            end
        end else if (counting) begin
            if (p) begin
                counting = 0; frozen = 1;
            end else begin
                rem = rem - 1;
                if (rem <= 0) finish_now();
            end
        end else if (frozen) begin
            if (!p) begin
                frozen = 0; counting = 1;
            end
        end else if (s) begin
            if (rem == 0) finish_now();
            else counting = 1;
        end
    endfunction

    function automatic void push_expected();
        exp_t e;
        e.count   = rem;
        e.busy    = counting | frozen;
        e.expired = m_expired;
        e.done    = m_pulse;
        exp_q.push_back(e);
    endfunction

    // One clock of stimulus: drive, let the edge happen, queue the expectation.
    task automatic step(input bit l, input int v, input bit s, input bit p);
        load       = l;
        load_value = v[W-1:0];
        start      = s;
        pause      = p;
        @(posedge clk);
        model_edge(l, v, s, p);
        #1;
        push_expected();
    endtask

    // Mid-cycle asynchronous reset, checked immediately and across one edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_count", count, MAXV);
        check("rst_busy", busy, 0);
        check("rst_expired", expired, 0);
        check("rst_done", done_pulse, 0);
        model_reset();
        @(posedge clk);
        #1 push_expected();
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    // Monitor: every registered output is presented each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", count, e.count);
                check("busy", busy, e.busy);
                check("expired", expired, e.expired);
                check("done_pulse", done_pulse, e.done);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; load = 0; load_value = '0; start = 0; pause = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 check("por_count", count, MAXV);
        check("por_busy", busy, 0);
        @(negedge clk) reset = 1'b0;

        // Full-scale countdown from the reset reload value.
        step(0, 0, 1, 0);
        n = 0;
        while (!expired && n < 100) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("lat_full", n, MAXV);

        // Load 5, pause for two sampled edges at count 3 -> 8 edges total.
        step(1, 5, 0, 0);
        step(0, 0, 1, 0);
        n = 0;
        step(0, 0, 0, 0); n++;
        step(0, 0, 0, 0); n++;
        step(0, 0, 0, 1); n++;
        step(0, 0, 0, 1); n++;
        while (!expired && n < 100) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("lat_pause", n, 8);

        // Load 0 then start -> immediate DONE.
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        check("zero_expired", expired, 1);
        step(0, 0, 0, 0);

        // Load and start together act as load only.
        step(1, 7, 1, 0);
        check("ldst_busy", busy, 0);
        step(0, 0, 1, 0);
        repeat (9) step(0, 0, 0, 0);

        // Restart from DONE reloads the last loaded value.
        step(1, 4, 0, 0);
        step(0, 0, 1, 0);
        repeat (5) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        check("restart_clr", expired, 0);
        n = 0;
        while (!expired && n < 100) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("lat_restart", n, 4);

        // Reset in the middle of a countdown.
        step(1, 10, 0, 0);
        step(0, 0, 1, 0);
        n = 0;
        while (count != 6 && n < 20) begin
            step(0, 0, 0, 0);
            n++;
        end
        check("reach6", count, 6);
        do_reset();
        step(0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 2500; i++) begin
            bit l, s, p;
            int v;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                l = ($urandom_range(0, 19) == 0);
                s = ($urandom_range(0, 3) == 0);
                p = ($urandom_range(0, 7) == 0);
                v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAXV) : $urandom_range(0, 6);
                step(l, v, s, p);
            end
        end

        step(0, 0, 0, 0);
        @(negedge clk);
        #1 check("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_countdown_timer
